gates_pipe: RTL and testbench
=============================

# gates_pipe

Parametrised, pipelined successor to the combinational `gates` block. It applies one of eight bitwise logic functions to two `WIDTH`-bit operands per beat. Operands enter through a valid/ready handshake and pass through two register stages, which absorb backpressure. An optional accumulate mode chains results across a burst. The block sits between an operand source and any downstream consumer that may stall.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits, ≥ 1.
- `CNT_W`, default 16: width of the delivered-beat counter.

Ports:
- `clk_in`, input, 1: single clock; all state changes on the rising edge.
- `rst_n_in`, input, 1: asynchronous, active-low reset.
- `a_in`, input, `WIDTH`: operand A.
- `b_in`, input, `WIDTH`: operand B.
- `op_in`, input, 3: function select; encoding is given under Operation.
- `acc_in`, input, 1: when 1, the accumulator replaces operand A for this beat.
- `last_in`, input, 1: marks the final beat of a burst.
- `valid_in`, input, 1: an input beat is present.
- `ready_out`, output, 1: the block can accept an input beat.
- `z_out`, output, `WIDTH`: result.
- `last_out`, output, 1: the `last_in` value of the delivered beat.
- `valid_out`, output, 1: `z_out` holds a result.
- `ready_in`, input, 1: the downstream consumer accepts the result.
- `count_out`, output, `CNT_W`: number of delivered beats, saturating.

## Operation
- Function encoding for `op_in`:
  - 0 AND, 1 OR, 2 NAND, 3 NOR
  - 4 XOR, 5 XNOR
  - 6 NOT A, 7 NOT B
  - Every function is applied bitwise over `WIDTH` bits.
- Input accept: a beat is accepted when `valid_in && ready_out`.
- Stage S1 register: captures `a`, `b`, `op`, `acc`, `last` on accept and sets `s1_valid`.
- S1 to S2 transfer, on an S2 load:
  - `opA = s1_acc ? acc_q : s1_a`
  - `z_q <= f(op, opA, s1_b)`
  - `last_q <= s1_last`
  - `valid_out <= 1`
- Accumulator `acc_q` (`WIDTH` bits) is updated on every S2 load:
  - `acc_q <= s1_last ? 0 : result`
  - This holds whether or not `acc` was set for that beat.
  - Back-to-back accumulate beats never hazard, because the accumulator reads and updates on the same edge.
- `count_out` increments on each `valid_out && ready_in` and holds at all-ones once it reaches all-ones.

## Timing
- Reset (asynchronous, mid-operation included):
  - `s1_valid = 0`, `valid_out = 0`, `z_out = 0`, `last_out = 0`, `acc_q = 0`, `count_out = 0`.
  - Any in-flight beats are discarded.
  - `ready_out` is 1 in the first cycle after reset is released.
- S2 advance condition: `s2_adv = !valid_out || ready_in`.
- S2 load: `s1_valid && s2_adv`. If `s2_adv` holds with `s1_valid = 0`, `valid_out` clears.
- Input ready: `ready_out = !s1_valid || s2_adv`. This is combinational from `ready_in`. There is no combinational path from `valid_in` to `ready_out`.
- Latency: with `ready_in` held at 1, a beat accepted at edge N appears at `valid_out` after edge N+1.
- Throughput is one beat per cycle while `ready_in = 1`.
- Stall (`ready_in = 0` with `valid_out = 1`):
  - `z_out`, `last_out`, and `valid_out` hold stable.
  - At most one more beat is accepted into S1, after which `ready_out` falls.
- Simultaneous S1 drain and new accept in the same cycle is legal; S1 is overwritten with the new beat.
- No loss or duplication of beats under any `ready_in` pattern.

## Structure
- Shared package `gates_pkg`:
  - `op_e`, a 3-bit enum of the eight codes above.
  - Function `gates_f(op, a, b)`, parametrised by `WIDTH` through the caller.
- One natural sub-module, `gates_pipe_stage`: a generic valid/ready register slice, instantiated for S1 (payload plus flags) and S2 (result plus last).
- The top level holds the accumulator, the operand mux, the function evaluation, and the counter.

## Test plan
- Function sweep: `WIDTH = 8`, `a = 0xC3`, `b = 0xA5`, ops 0–7, `ready_in = 1`. Required `z` sequence: 0x81, 0xE7, 0x7E, 0x18, 0x66, 0x99, 0x3C, 0x5A, each arriving 2 cycles after accept; `count_out = 8` at the end.
- Accumulate burst: XOR beats with `b` = 0x01, 0x02, 0x04 and `last` on the third. The first beat has `acc = 0`, `a = 0xF0`; the rest have `acc = 1`. Required: `z` = 0xF1, 0xF3, 0xF7, then `acc_q = 0` after the last beat.
- Backpressure: `ready_in = 0` for 5 cycles while `valid_in` is held at 1. Required:
  - exactly 2 beats accepted, then `ready_out = 0`;
  - `z_out` stable throughout the stall;
  - after release, all beats are delivered in order with no gaps or duplicates.
- Random stall: 1000 random beats with random `valid_in`/`ready_in`, checked against a reference queue model. Required: exact in-order match.
- Reset mid-burst: assert `rst_n_in` low while S1 and S2 are full. Required:
  - `valid_out = 0` and `count_out = 0` immediately, without waiting for a clock;
  - after release, a following AND of `acc = 1` with `b = 0xFF` yields 0x00.
- Saturation: `CNT_W = 4`, 20 delivered beats. Required: `count_out = 0xF`, held.

Source files
------------

// File: rtl/gates_pkg.sv
// Shared definitions for the pipelined bitwise-gates block: the function code enum,
// the S1 flag bundle and the single-bit function evaluator.
package gates_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOTA = 3'd6,
    OP_NOTB = 3'd7
  } op_e;

  typedef struct packed {
    op_e  op;
    logic acc;
    logic last;
  } s1_flags_t;

  localparam int S1_FLAGS_W = $bits(s1_flags_t);

  // One bit of the selected function; callers replicate it across their own width.
  function automatic logic gates_f(input op_e op, input logic a, input logic b);
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_NOTA: r = ~a;
      OP_NOTB: r = ~b;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gates_pipe_stage.sv
// Generic valid/ready register slice: one entry, full-throughput, ready looks only
// at its own occupancy and the downstream ready.
module gates_pipe_stage #(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          ready_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  input  logic          ready_i
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  assign ready_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ready_o) begin
      // Draining with nothing new arriving empties the slot.
      valid_d = valid_i;
      if (valid_i) begin
        data_d = data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/gates_pipe.sv
// Two-stage pipelined bitwise gate array with accumulate chaining across a burst
// and a saturating delivered-beat counter.
module gates_pipe
  import gates_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [2:0]       op_in,
  input  logic             acc_in,
  input  logic             last_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] z_out,
  output logic             last_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [CNT_W-1:0] count_out
);

  localparam int S1_W = 2 * WIDTH + S1_FLAGS_W;

  s1_flags_t        flags_in;
  logic [S1_W-1:0]  s1_data_in;
  logic [S1_W-1:0]  s1_data;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_b;
  s1_flags_t        s1_flags;

  logic             s2_adv;
  logic             s2_load;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] result;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign flags_in   = '{op: op_e'(op_in), acc: acc_in, last: last_in};
  assign s1_data_in = {a_in, b_in, flags_in};

  gates_pipe_stage #(.DW(S1_W)) u_s1 (
    .clk_i   (clk_in),
    .rst_ni  (rst_n_in),
    .valid_i (valid_in),
    .data_i  (s1_data_in),
    .ready_o (ready_out),
    .valid_o (s1_valid),
    .data_o  (s1_data),
    .ready_i (s2_adv)
  );

  assign {s1_a, s1_b, s1_flags} = s1_data;

  // The accumulator is read here and rewritten on the same edge that loads S2,
  // so consecutive accumulate beats always see the previous beat's result.
  assign op_a = s1_flags.acc ? acc_q : s1_a;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign result[gi] = gates_f(s1_flags.op, op_a[gi], s1_b[gi]);
  end

  gates_pipe_stage #(.DW(WIDTH + 1)) u_s2 (
    .clk_i   (clk_in),
    .rst_ni  (rst_n_in),
    .valid_i (s1_valid),
    .data_i  ({result, s1_flags.last}),
    .ready_o (s2_adv),
    .valid_o (valid_out),
    .data_o  ({z_out, last_out}),
    .ready_i (ready_in)
  );

  assign s2_load = s1_valid && s2_adv;

  always_comb begin
    acc_d = acc_q;
    if (s2_load) begin
      acc_d = s1_flags.last ? '0 : result;
    end
  end

  always_comb begin
    count_d = count_q;
    if (valid_out && ready_in && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule

// File: tb/tb_gates_pipe.sv
// Scoreboard bench for gates_pipe: stimulus pushes expected beats, a negedge
// monitor pops and compares every delivered beat.
module tb_gates_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       acc, last, valid, ready_in;

  logic       ready_out, last_out, valid_out;
  logic [7:0] z_out;
  logic [15:0] count_out;

  logic       s_ready_out, s_last_out, s_valid_out;
  logic [7:0] s_z_out;
  logic [3:0] s_count_out;

  always #5 clk = ~clk;

  gates_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .a_in(a), .b_in(b), .op_in(op),
    .acc_in(acc), .last_in(last), .valid_in(valid), .ready_out(ready_out),
    .z_out(z_out), .last_out(last_out), .valid_out(valid_out),
    .ready_in(ready_in), .count_out(count_out)
  );

  gates_pipe #(.WIDTH(8), .CNT_W(4)) dut_sat (
    .clk_in(clk), .rst_n_in(rst_n), .a_in(a), .b_in(b), .op_in(op),
    .acc_in(acc), .last_in(last), .valid_in(valid), .ready_out(s_ready_out),
    .z_out(s_z_out), .last_out(s_last_out), .valid_out(s_valid_out),
    .ready_in(ready_in), .count_out(s_count_out)
  );

  typedef struct packed {
    logic [7:0] z;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   delivered = 0;
  int   cyc = 0;
  logic [7:0] model_acc;

  always @(posedge clk) cyc++;

  // Monitor: every handshake at the coming edge must match the queue head.
  always @(negedge clk) begin
    if (rst_n && valid_out && ready_in) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat got z=%02h last=%0b required none", z_out, last_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (z_out !== e.z || last_out !== e.last) begin
          errors++;
          $display("FAIL beat%0d got z=%02h last=%0b required z=%02h last=%0b",
                   delivered, z_out, last_out, e.z, e.last);
        end else begin
          $display("beat%0d z=%02h last=%0b ok", delivered, z_out, last_out);
        end
      end
      delivered++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] ref_f(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return ~(x & y);
      3'd3:    return ~(x | y);
      3'd4:    return x ^ y;
      3'd5:    return ~(x ^ y);
      3'd6:    return ~x;
      default: return ~y;
    endcase
  endfunction

  // Presents a beat, holds it until accepted, records its expected result.
  task automatic send(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] iop,
                      input logic iacc, input logic ilast, input logic [7:0] ez);
    int t;
    t = 0;
    a = ia; b = ib; op = iop; acc = iacc; last = ilast; valid = 1'b1;
    forever begin
      @(negedge clk);
      if (ready_out) break;
      t++;
      if (t > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout got ready_out=0 required 1");
        break;
      end
    end
    exp_q.push_back('{z: ez, last: ilast});
    $display("send a=%02h b=%02h op=%0d acc=%0b last=%0b exp=%02h", ia, ib, iop, iacc, ilast, ez);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(posedge clk);
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  logic [7:0] sweep_z [8] = '{8'h81, 8'hE7, 8'h7E, 8'h18, 8'h66, 8'h99, 8'h3C, 8'h5A};
  logic [7:0] bp_a  [4] = '{8'h0F, 8'h30, 8'h00, 8'hAA};
  logic [7:0] bp_b  [4] = '{8'hFF, 8'h03, 8'h0F, 8'hAA};
  logic [2:0] bp_op [4] = '{3'd0, 3'd1, 3'd3, 3'd5};
  logic [7:0] bp_z  [4] = '{8'h0F, 8'h33, 8'hF0, 8'hFF};

  initial begin
    int c0, acc_cnt, sent, guard, d0;
    logic took;
    rst_n = 1'b0; a = '0; b = '0; op = '0; acc = 1'b0; last = 1'b0;
    valid = 1'b0; ready_in = 1'b1; model_acc = '0;
    #12;
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_z_out", 32'(z_out), 32'd0);
    chk("rst_last_out", 32'(last_out), 32'd0);
    chk("rst_count", 32'(count_out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_ready_out", 32'(ready_out), 32'd1);

    // Function sweep; first beat alone to pin the two-edge latency.
    send(8'hC3, 8'hA5, 3'd0, 1'b0, 1'b0, sweep_z[0]);
    valid = 1'b0;
    @(negedge clk);
    chk("lat_valid_early", 32'(valid_out), 32'd0);
    @(negedge clk);
    chk("lat_valid_on_time", 32'(valid_out), 32'd1);
    @(posedge clk); #1;
    c0 = cyc;
    for (int i = 1; i < 8; i++) send(8'hC3, 8'hA5, 3'(i), 1'b0, 1'b0, sweep_z[i]);
    chk("sweep_throughput_cycles", 32'(cyc - c0), 32'd7);
    valid = 1'b0;
    drain();
    chk("sweep_count", 32'(count_out), 32'd8);

    // Accumulate burst, then an accumulate XOR with zero exposes acc_q.
    send(8'hF0, 8'h01, 3'd4, 1'b0, 1'b0, 8'hF1);
    send(8'h00, 8'h02, 3'd4, 1'b1, 1'b0, 8'hF3);
    send(8'h00, 8'h04, 3'd4, 1'b1, 1'b1, 8'hF7);
    send(8'hFF, 8'h00, 3'd4, 1'b1, 1'b1, 8'h00);
    valid = 1'b0;
    drain();

    // Backpressure with valid held high.
    d0 = delivered;
    ready_in = 1'b0;
    acc_cnt = 0;
    a = bp_a[0]; b = bp_b[0]; op = bp_op[0]; acc = 1'b0; last = 1'b0; valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      took = ready_out;
      if (c >= 2) begin
        chk("stall_z_stable", 32'(z_out), 32'(bp_z[0]));
        chk("stall_valid_out", 32'(valid_out), 32'd1);
      end
      if (took) begin
        exp_q.push_back('{z: bp_z[acc_cnt], last: 1'b0});
        $display("send a=%02h b=%02h op=%0d acc=0 last=0 exp=%02h (stalled)",
                 bp_a[acc_cnt], bp_b[acc_cnt], bp_op[acc_cnt], bp_z[acc_cnt]);
        acc_cnt++;
      end
      @(posedge clk); #1;
      if (took) begin
        a = bp_a[acc_cnt]; b = bp_b[acc_cnt]; op = bp_op[acc_cnt];
      end
    end
    chk("stall_accepted", 32'(acc_cnt), 32'd2);
    chk("stall_ready_low", 32'(ready_out), 32'd0);
    ready_in = 1'b1;
    send(bp_a[2], bp_b[2], bp_op[2], 1'b0, 1'b0, bp_z[2]);
    send(bp_a[3], bp_b[3], bp_op[3], 1'b0, 1'b1, bp_z[3]);
    valid = 1'b0;
    drain();
    chk("stall_delivered", 32'(delivered - d0), 32'd4);

    // Random valid/ready against the reference model.
    model_acc = '0;
    sent = 0; guard = 0;
    d0 = delivered;
    while (sent < 1000 && guard < 20000) begin
      guard++;
      ready_in = ($urandom_range(0, 3) != 0);
      if (!valid && $urandom_range(0, 2) != 0) begin
        a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 7));
        acc = 1'($urandom_range(0, 1)); last = ($urandom_range(0, 7) == 0);
        valid = 1'b1;
      end
      @(negedge clk);
      took = valid && ready_out;
      if (took) begin
        logic [7:0] r;
        r = ref_f(op, acc ? model_acc : a, b);
        model_acc = last ? 8'h00 : r;
        exp_q.push_back('{z: r, last: last});
        sent++;
      end
      @(posedge clk); #1;
      if (took) valid = 1'b0;
    end
    chk("rand_sent", 32'(sent), 32'd1000);
    ready_in = 1'b1;
    valid = 1'b0;
    drain();
    chk("rand_delivered", 32'(delivered - d0), 32'd1000);
    chk("rand_count", 32'(count_out), 32'(delivered));
    chk("rand_sat_count", 32'(s_count_out), 32'hF);

    // Reset with both stages full and acc_q non-zero.
    ready_in = 1'b0;
    send(8'h55, 8'h00, 3'd1, 1'b0, 1'b0, 8'h55);
    send(8'hFF, 8'h0F, 3'd0, 1'b0, 1'b0, 8'h0F);
    valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid_out", 32'(valid_out), 32'd0);
    chk("midrst_count", 32'(count_out), 32'd0);
    chk("midrst_sat_count", 32'(s_count_out), 32'd0);
    exp_q.delete();
    delivered = 0;
    ready_in = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_ready_out", 32'(ready_out), 32'd1);
    send(8'h77, 8'hFF, 3'd0, 1'b1, 1'b1, 8'h00);
    valid = 1'b0;
    drain();
    chk("midrst_count_after", 32'(count_out), 32'd1);

    // Saturation of the 4-bit counter.
    for (int i = 0; i < 20; i++) send(8'(i), 8'h00, 3'd4, 1'b0, 1'b0, 8'(i));
    valid = 1'b0;
    drain();
    chk("sat_count", 32'(s_count_out), 32'hF);
    chk("wide_count", 32'(count_out), 32'd21);
    send(8'h01, 8'h01, 3'd0, 1'b0, 1'b0, 8'h01);
    valid = 1'b0;
    drain();
    chk("sat_count_held", 32'(s_count_out), 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
